// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared audio datapath constants and sample type, used by the
//                equalizer filters and the I2S transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int WD_SAMPLE = 24;   // signed sample width per channel
    localparam int SLOT_W    = 32;   // BCLK cycles per I2S channel slot

    typedef logic signed [WD_SAMPLE-1:0] sample_t;

    // Counter width for a range of v states; never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_bclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_bclk_gen
//  Description : Divides clk down to the I2S bit clock. bclk toggles every
//                BCLK_DIV clk cycles; rise/fall are one-clk strobes that are
//                high on the clk edge at which bclk makes that transition.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_bclk_gen
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int                DIV_W    = clog2_min1(BCLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);

    generate
        if (BCLK_DIV < 1) begin : g_div_check
            $error("i2s_bclk_gen: BCLK_DIV must be >= 1");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;

    assign div_wrap = (div_cnt == DIV_LAST);

    // Strobes announce the toggle that happens on this edge, so consumers
    // can update in lockstep with bclk itself.
    assign rise = div_wrap && !bclk;
    assign fall = div_wrap &&  bclk;

    // Half-period counter; bclk flips each time the counter wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx
//  Description : Standard (Philips) I2S transmitter. Accepts a left/right
//                sample pair into a one-deep shadow register and serialises
//                it MSB first, LSB zero-padded to SLOT bits per channel, with
//                lrclk leading each slot MSB by one BCLK.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx
    import audio_pkg::*;
#(
    parameter int WD_IN    = WD_SAMPLE,
    parameter int SLOT     = SLOT_W,
    parameter int BCLK_DIV = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic signed [WD_IN-1:0] l_data,
    input  logic signed [WD_IN-1:0] r_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    underrun
);

    localparam int               FRAME    = 2 * SLOT;
    localparam int               K_W      = clog2_min1(FRAME);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(FRAME - 1);
    localparam logic [K_W-1:0]   LR_FIRST = K_W'(SLOT - 1);
    localparam logic [K_W-1:0]   LR_LAST  = K_W'(FRAME - 2);

    generate
        if (WD_IN > SLOT || WD_IN < 1) begin : g_width_check
            $error("i2s_tx: WD_IN must be in 1..SLOT");
        end
    endgenerate

    // Rise strobe is not needed on the transmit side; kept for a receive path.
    logic bclk_rise_unused;
    logic bclk_fall;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .bclk    (bclk),
        .rise    (bclk_rise_unused),
        .fall    (bclk_fall)
    );

    logic [K_W-1:0]   k;
    logic [K_W-1:0]   k_next;
    logic             lr_next;
    logic             full;
    logic [WD_IN-1:0] shadow_l;
    logic [WD_IN-1:0] shadow_r;
    logic [FRAME-1:0] frame_sr;
    logic [SLOT-1:0]  slot_l;
    logic [SLOT-1:0]  slot_r;
    logic [FRAME-1:0] load_frame;
    logic             transfer;
    logic             frame_load;

    assign in_ready   = !full;
    assign transfer   = in_valid && !full;
    assign frame_load = bclk_fall && (k == K_LAST);
    assign k_next     = (k == K_LAST) ? '0 : k + 1'b1;
    assign lr_next    = (k_next >= LR_FIRST) && (k_next <= LR_LAST);

    // Left-justify each sample in its slot; unused LSBs are zero.
    assign slot_l     = SLOT'(shadow_l) << (SLOT - WD_IN);
    assign slot_r     = SLOT'(shadow_r) << (SLOT - WD_IN);
    // Frame decision uses the flag before this edge's transfer, so a pair
    // arriving on the load edge waits for the next frame.
    assign load_frame = full ? {slot_l, slot_r} : '0;

    // Shadow pair register: a frame load empties it, a transfer fills it;
    // both on one edge can only happen from empty and leave it full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full     <= 1'b0;
            shadow_l <= '0;
            shadow_r <= '0;
        end else begin
            if (frame_load) begin
                full <= transfer;
            end else if (transfer) begin
                full <= 1'b1;
            end
            if (transfer) begin
                shadow_l <= l_data;
                shadow_r <= r_data;
            end
        end
    end

    // Bit counter and serialiser; everything advances on bclk fall so the
    // DAC sees stable data on the following rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k        <= K_LAST;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            frame_sr <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (bclk_fall) begin
                k     <= k_next;
                lrclk <= lr_next;
                if (frame_load) begin
                    sdata    <= load_frame[FRAME-1];
                    frame_sr <= {load_frame[FRAME-2:0], 1'b0};
                    underrun <= !full;
                end else begin
                    sdata    <= frame_sr[FRAME-1];
                    frame_sr <= {frame_sr[FRAME-2:0], 1'b0};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_tx
//  Description : Directed self-checking bench for i2s_tx at default
//                parameters (24-bit samples, 32-bit slots, BCLK_DIV = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

    localparam int DIV = 4;

    logic               clk      = 1'b0;
    logic               reset_n  = 1'b0;
    logic signed [23:0] l_data   = '0;
    logic signed [23:0] r_data   = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               bclk;
    logic               lrclk;
    logic               sdata;
    logic               underrun;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic drive_on = 1'b0;

    always #5 clk = ~clk;

    i2s_tx #(
        .WD_IN    (24),
        .SLOT     (32),
        .BCLK_DIV (DIV)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .l_data   (l_data),
        .r_data   (r_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun)
    );

    // Hand-built expected frame: each sample left-justified, 8 zero LSBs.
    function automatic logic [63:0] frame_of(input logic [23:0] l, input logic [23:0] r);
        return {l, 8'h00, r, 8'h00};
    endfunction

    function automatic logic [23:0] pair_l(input int j);
        return 24'(j * 32'h0001_0203) ^ 24'h80_0000;
    endfunction

    function automatic logic [23:0] pair_r(input int j);
        return ~pair_l(j);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance to just after the next bclk falling edge (a new bit index k).
    task automatic next_fall();
        logic p;
        for (int i = 0; i < 4 * DIV; i++) begin
            p = bclk;
            tick();
            if (p && !bclk) return;
        end
        total_cnt++;
        $display("FAIL next_fall: no bclk fall within %0d clk", 4 * DIV);
    endtask

    // Record sdata/lrclk for k = 0..63; bit 63-k holds the value at index k.
    task automatic capture_frame(input bit have_first, output logic [63:0] sd,
                                 output logic [63:0] lr, output int und);
        und = 0;
        for (int i = 0; i < 64; i++) begin
            if (!(i == 0 && have_first)) next_fall();
            sd[63-i] = sdata;
            lr[63-i] = lrclk;
            if (underrun) und++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        total_cnt++; if (bclk !== 1'b0)     $display("FAIL reset_bclk: got %b want 0", bclk);         else pass_cnt++;
        total_cnt++; if (lrclk !== 1'b0)    $display("FAIL reset_lrclk: got %b want 0", lrclk);       else pass_cnt++;
        total_cnt++; if (sdata !== 1'b0)    $display("FAIL reset_sdata: got %b want 0", sdata);       else pass_cnt++;
        total_cnt++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_first_frame();
        logic [63:0] sd, lr;
        int und;
        l_data   = 24'h80_0001;
        r_data   = 24'h7F_FFFF;
        in_valid = 1'b1;
        reset_n  = 1'b1;
        tick();                                   // edge 1: pair accepted
        in_valid = 1'b0;
        l_data   = '0;
        r_data   = '0;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL first_full: in_ready got %b want 0", in_ready); else pass_cnt++;
        repeat (2) tick();                        // edge 3
        total_cnt++; if (bclk !== 1'b0) $display("FAIL first_edge3_bclk: got %b want 0", bclk); else pass_cnt++;
        tick();                                   // edge 4: first rise
        total_cnt++; if (bclk !== 1'b1) $display("FAIL first_rise_edge4: got %b want 1", bclk); else pass_cnt++;
        repeat (3) tick();                        // edge 7
        total_cnt++; if (bclk !== 1'b1) $display("FAIL first_edge7_bclk: got %b want 1", bclk); else pass_cnt++;
        total_cnt++; if (sdata !== 1'b0) $display("FAIL first_edge7_sdata: got %b want 0", sdata); else pass_cnt++;
        tick();                                   // edge 8: first fall, k = 0
        total_cnt++; if (bclk !== 1'b0)     $display("FAIL first_fall_edge8: got %b want 0", bclk);       else pass_cnt++;
        total_cnt++; if (sdata !== 1'b1)    $display("FAIL first_msb: got %b want 1", sdata);             else pass_cnt++;
        total_cnt++; if (underrun !== 1'b0) $display("FAIL first_underrun: got %b want 0", underrun);     else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL first_ready_after_load: got %b want 1", in_ready); else pass_cnt++;
        capture_frame(1'b1, sd, lr, und);
        total_cnt++; if (sd !== frame_of(24'h80_0001, 24'h7F_FFFF))
            $display("FAIL first_frame_bits: got %h want %h", sd, frame_of(24'h80_0001, 24'h7F_FFFF)); else pass_cnt++;
        total_cnt++; if (sd[63:40] !== 24'h80_0001) $display("FAIL first_left_value: got %h want 800001", sd[63:40]); else pass_cnt++;
        total_cnt++; if (sd[31:8] !== 24'h7F_FFFF)  $display("FAIL first_right_value: got %h want 7fffff", sd[31:8]); else pass_cnt++;
        total_cnt++; if (lr !== 64'h0000_0001_FFFF_FFFE)
            $display("FAIL first_lrclk_pattern: got %h want 00000001fffffffe", lr); else pass_cnt++;
        total_cnt++; if (und !== 0) $display("FAIL first_frame_underruns: got %0d want 0", und); else pass_cnt++;
    endtask

    task automatic test_underrun();
        logic [63:0] sd, lr;
        int und;
        for (int f = 0; f < 2; f++) begin
            capture_frame(1'b0, sd, lr, und);
            total_cnt++; if (sd !== 64'h0) $display("FAIL underrun_frame%0d_bits: got %h want 0", f, sd); else pass_cnt++;
            total_cnt++; if (und !== 1) $display("FAIL underrun_frame%0d_pulses: got %0d want 1", f, und); else pass_cnt++;
        end
        next_fall();                              // k = 0 of a third empty frame
        total_cnt++; if (underrun !== 1'b1) $display("FAIL underrun_pulse_high: got %b want 1", underrun); else pass_cnt++;
        tick();
        total_cnt++; if (underrun !== 1'b0) $display("FAIL underrun_pulse_width: got %b want 0", underrun); else pass_cnt++;
        for (int i = 0; i < 63; i++) next_fall(); // back to k = 63
    endtask

    task automatic test_load_collision();
        logic [63:0] sd, lr;
        int und;
        repeat (7) tick();
        l_data   = 24'h12_3456;
        r_data   = 24'hFE_DCBA;
        in_valid = 1'b1;
        tick();                                   // frame-load edge, full was 0
        in_valid = 1'b0;
        total_cnt++; if (bclk !== 1'b0)     $display("FAIL coll_on_fall: bclk got %b want 0", bclk);     else pass_cnt++;
        total_cnt++; if (underrun !== 1'b1) $display("FAIL coll_underrun: got %b want 1", underrun);     else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL coll_pair_held: in_ready got %b want 0", in_ready); else pass_cnt++;
        capture_frame(1'b1, sd, lr, und);
        total_cnt++; if (sd !== 64'h0) $display("FAIL coll_zero_frame: got %h want 0", sd); else pass_cnt++;
        total_cnt++; if (und !== 1) $display("FAIL coll_zero_frame_pulses: got %0d want 1", und); else pass_cnt++;
        capture_frame(1'b0, sd, lr, und);
        total_cnt++; if (sd !== frame_of(24'h12_3456, 24'hFE_DCBA))
            $display("FAIL coll_next_frame: got %h want %h", sd, frame_of(24'h12_3456, 24'hFE_DCBA)); else pass_cnt++;
        total_cnt++; if (und !== 0) $display("FAIL coll_next_underruns: got %0d want 0", und); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] sd, lr;
        int und;
        int xfers;
        int ready_cycles;
        xfers        = 0;
        ready_cycles = 0;
        l_data   = pair_l(1);
        r_data   = pair_r(1);
        in_valid = 1'b1;
        drive_on = 1'b1;
        fork
            begin
                for (int j = 1; j <= 10; j++) begin
                    capture_frame(1'b0, sd, lr, und);
                    total_cnt++; if (sd !== frame_of(pair_l(j), pair_r(j)))
                        $display("FAIL b2b_frame%0d: got %h want %h", j, sd, frame_of(pair_l(j), pair_r(j))); else pass_cnt++;
                    total_cnt++; if (und !== 0) $display("FAIL b2b_frame%0d_underrun: got %0d want 0", j, und); else pass_cnt++;
                end
                drive_on = 1'b0;
            end
            begin
                logic hs;
                while (drive_on) begin
                    @(negedge clk);
                    hs = in_valid && in_ready;
                    if (in_ready) ready_cycles++;
                    @(posedge clk);
                    #1;
                    if (hs) begin
                        xfers++;
                        l_data = pair_l(xfers + 1);
                        r_data = pair_r(xfers + 1);
                    end
                end
            end
        join
        in_valid = 1'b0;
        total_cnt++; if (xfers !== 11) $display("FAIL b2b_transfers: got %0d want 11", xfers); else pass_cnt++;
        total_cnt++; if (ready_cycles !== 11) $display("FAIL b2b_ready_cycles: got %0d want 11", ready_cycles); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        logic [63:0] sd, lr;
        int und;
        next_fall();                              // k = 0, held pair goes out
        tick();
        l_data   = 24'h55_AA55;
        r_data   = 24'hAA_55AA;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) next_fall(); // k = 40
        repeat (5) tick();                        // bclk high mid-bit
        total_cnt++; if (lrclk !== 1'b1)    $display("FAIL mid_pre_lrclk: got %b want 1", lrclk);       else pass_cnt++;
        total_cnt++; if (bclk !== 1'b1)     $display("FAIL mid_pre_bclk: got %b want 1", bclk);         else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL mid_pre_full: in_ready got %b want 0", in_ready); else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (bclk !== 1'b0)     $display("FAIL mid_rst_bclk: got %b want 0", bclk);         else pass_cnt++;
        total_cnt++; if (lrclk !== 1'b0)    $display("FAIL mid_rst_lrclk: got %b want 0", lrclk);       else pass_cnt++;
        total_cnt++; if (sdata !== 1'b0)    $display("FAIL mid_rst_sdata: got %b want 0", sdata);       else pass_cnt++;
        total_cnt++; if (underrun !== 1'b0) $display("FAIL mid_rst_underrun: got %b want 0", underrun); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
        repeat (3) tick();
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            total_cnt++; if (bclk !== ((e >= 4 && e < 8) ? 1'b1 : 1'b0))
                $display("FAIL release_bclk_edge%0d: got %b want %b", e, bclk, (e >= 4 && e < 8)); else pass_cnt++;
        end
        total_cnt++; if (underrun !== 1'b1) $display("FAIL release_discard_underrun: got %b want 1", underrun); else pass_cnt++;
        capture_frame(1'b1, sd, lr, und);
        total_cnt++; if (sd !== 64'h0) $display("FAIL release_discard_frame: got %h want 0", sd); else pass_cnt++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_frame();
        test_underrun();
        test_load_collision();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter WD_IN, default 24, meaning signed sample width per channel.
REQ-002 SHALL have parameter SLOT, default 32, meaning BCLK cycles per channel slot; WD_IN <= SLOT checked at elaboration.
REQ-003 SHALL have parameter BCLK_DIV, default 4, meaning clk cycles per BCLK half-period; BCLK_DIV >= 1.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 l_data  input  WD_IN  signed left sample from the equalizer output.
REQ-007 r_data  input  WD_IN  signed right sample.
REQ-008 in_valid  input  1  l_data/r_data pair valid.
REQ-009 in_ready  output  1  holding register empty; transfer on in_valid && in_ready at a clk edge.
REQ-010 bclk  output  1  serial bit clock to DAC.
REQ-011 lrclk  output  1  word select; 0 = left, 1 = right.
REQ-012 sdata  output  1  serial data, MSB first.
REQ-013 underrun  output  1  one-clk pulse when a frame starts with no sample pair available.

Function
REQ-014 div_cnt SHALL count 0..BCLK_DIV-1; at BCLK_DIV-1 it wraps to 0 and bclk toggles; a 0->1 toggle is a rise strobe, 1->0 a fall strobe.
REQ-015 bit_cnt k SHALL range 0..2*SLOT-1, advance by one (wrapping 2*SLOT-1 -> 0) only on fall strobes; sdata and lrclk change only on fall strobes.
REQ-016 With new k: lrclk SHALL be 1 for k in [SLOT-1, 2*SLOT-2], else 0, so lrclk leads each slot MSB by one BCLK (standard I2S delay).
REQ-017 For k in [0, SLOT-1], sdata SHALL be left bit (WD_IN-1-k) for k < WD_IN, else 0; for k in [SLOT, 2*SLOT-1], the same for right with index k-SLOT.
REQ-018 Samples SHALL pass unaltered in two's complement; LSB zero-padding only, no rounding or saturation.
REQ-019 Shadow pair register with full flag; in_ready SHALL equal !full, driven by the flag register.
REQ-020 On the fall strobe with k wrapping to 0: if full, active frame register SHALL load from the shadow and full clears; if empty, active frame loads zeros and underrun pulses for that clk.
REQ-021 Simultaneous transfer and frame load on one clk with full=0: the frame SHALL see empty (zeros, underrun), and the new pair SHALL be stored with full=1.
REQ-022 With full=1 and frame load on the same clk, in_ready is 0, so no transfer occurs; full SHALL read 0 next cycle.
REQ-023 in_valid while in_ready=0 SHALL be ignored, with no data captured.
REQ-024 Throughput SHALL be one pair per 2*SLOT BCLK periods; a pair accepted before frame start SHALL appear starting at that frame's k=0.

Reset
REQ-025 While reset_n=0: bclk=0, lrclk=0, sdata=0, underrun=0, in_ready=1, div_cnt=0, k=2*SLOT-1, shadow/active=0, full=0.
REQ-026 After release, the first bclk rise SHALL occur on the BCLK_DIV-th clk edge and the first fall on the 2*BCLK_DIV-th, which SHALL start frame k=0.
REQ-027 Reset assertion mid-frame SHALL abort immediately to REQ-025 values, discarding held samples.

Structure
REQ-028 Shared package audio_pkg SHALL hold WD_SAMPLE=24, SLOT_W=32, and typedef sample_t (logic signed [WD_SAMPLE-1:0]), shared with the equalizer filters.
REQ-029 Sub-module i2s_bclk_gen SHALL own div_cnt and bclk and output rise/fall strobes; i2s_tx owns bit counter, shift/frame logic and handshake.

Verification
REQ-030 Reset release, BCLK_DIV=4: bclk period 8 clk; first fall at clk edge 8; lrclk rises on the fall where k=31, falls where k=63.
REQ-031 Load L=24'h800001, R=24'h7FFFFF before frame 0: left slot bits 1,0...0,1 then 8 zeros; right slot 0,1...1 then 8 zeros; frame-capture checker reconstructs both values.
REQ-032 No in_valid at frame start: sdata all zero for the frame, one underrun pulse per frame start.
REQ-033 Hold in_valid=1 continuously with incrementing pairs: in_ready high for 1 clk per frame after each load, no pair lost or duplicated over 10 frames.
REQ-034 Transfer on exactly the frame-load clk with full=0: underrun=1, zero frame, and the pair appears in the following frame.
REQ-035 Assert reset_n=0 at k=40: outputs match REQ-025 within the same clk, with no glitch on release.
